ofs_fim_pcie_ss_rx_class_split: RTL and testbench

OFS_FIM_PCIE_SS_RX_CLASS_SPLIT -- requirements
Module: ofs_fim_pcie_ss_rx_class_split

---
 rtl/ofs_fim_pcie_ss_rx_class_split.sv | 165 ++++++++++++++++
 tb/tb_ofs_fim_pcie_ss_rx_class_split.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ofs_fim_pcie_ss_rx_class_split.sv
`default_nettype none
// ============================================================================
// Module   : ofs_fim_pcie_ss_rx_class_split
// Brief    : Splits one AXI-S TLP stream into NUM_OUT per-class FIFO outputs
//            keyed on the SOP header fmt_type.
// Revision : 1.0 - initial release
// ============================================================================
module ofs_fim_pcie_ss_rx_class_split #(
    parameter int TDATA_WIDTH = 512,
    parameter int TKEEP_WIDTH = TDATA_WIDTH / 8,
    parameter int NUM_OUT     = 3,
    parameter int FIFO_DEPTH  = 64
) (
    input  logic                                       clk,
    input  logic                                       rst,

    input  logic                                       s_tvalid,
    output logic                                       s_tready,
    input  logic [TDATA_WIDTH-1:0]                     s_tdata,
    input  logic [TKEEP_WIDTH-1:0]                     s_tkeep,
    input  logic                                       s_tlast,
    input  logic                                       s_tuser_hvalid,
    input  logic [255:0]                               s_tuser_hdr,
    input  logic                                       s_tuser_vendor,

    output logic [NUM_OUT-1:0]                         m_tvalid,
    input  logic [NUM_OUT-1:0]                         m_tready,
    output logic [NUM_OUT*TDATA_WIDTH-1:0]             m_tdata,
    output logic [NUM_OUT*TKEEP_WIDTH-1:0]             m_tkeep,
    output logic [NUM_OUT-1:0]                         m_tlast,
    output logic [NUM_OUT-1:0]                         m_tuser_hvalid,
    output logic [NUM_OUT*256-1:0]                     m_tuser_hdr,
    output logic [NUM_OUT-1:0]                         m_tuser_vendor,

    output logic [NUM_OUT*($clog2(FIFO_DEPTH)+1)-1:0]  fill_level,
    output logic [NUM_OUT*16-1:0]                      pkt_cnt,
    output logic                                       err_no_hdr
);

    localparam int c_AW = $clog2(FIFO_DEPTH);
    localparam int c_PW = c_AW + 1;
    localparam int c_DW = (NUM_OUT > 2) ? 2 : 1;
    localparam int c_EW = TDATA_WIDTH + TKEEP_WIDTH + 3 + 256;

    localparam logic [c_DW-1:0] c_DEST_LAST = c_DW'(NUM_OUT - 1);
    localparam logic [c_DW-1:0] c_DEST_MSG  = (NUM_OUT >= 3) ? c_DW'(2) : c_DW'(1);
    localparam logic [c_PW-1:0] c_FULL      = c_PW'(FIFO_DEPTH);

    localparam logic [0:0] c_ST_SOP    = 1'b0;
    localparam logic [0:0] c_ST_IN_PKT = 1'b1;

    logic [0:0]      r_state;
    logic [0:0]      w_state_nxt;
    logic [c_DW-1:0] r_dest;
    logic [c_DW-1:0] w_dest_sop;
    logic [c_DW-1:0] w_dest;
    logic [7:0]      w_fmt_type;
    logic            w_push;
    logic            r_err;
    logic [c_EW-1:0] w_din;
    logic [c_PW-1:0] w_fill [NUM_OUT];

    assign w_fmt_type = s_tuser_hdr[31:24];

    // Class decode; a headerless SOP falls into the catch-all output.
    always_comb begin
        w_dest_sop = c_DEST_LAST;
        if (!s_tuser_hvalid) begin
            w_dest_sop = c_DEST_LAST;
        end else if (w_fmt_type == 8'h0A || w_fmt_type == 8'h4A) begin
            w_dest_sop = '0;
        end else if (w_fmt_type == 8'h00 || w_fmt_type == 8'h20 ||
                     w_fmt_type == 8'h40 || w_fmt_type == 8'h60) begin
            w_dest_sop = c_DW'(1);
        end else if (w_fmt_type[4:3] == 2'b10) begin
            w_dest_sop = c_DEST_MSG;
        end
    end

    assign w_dest   = (r_state == c_ST_IN_PKT) ? r_dest : w_dest_sop;
    // Ready only looks at registered fill, so m_tready never reaches it combinationally.
    assign s_tready = !rst && (w_fill[w_dest] < c_FULL);
    assign w_push   = s_tvalid && s_tready;
    assign w_din    = {s_tdata, s_tkeep, s_tlast, s_tuser_hvalid, s_tuser_hdr, s_tuser_vendor};

    always_comb begin
        w_state_nxt = r_state;
        if (w_push) begin
            w_state_nxt = s_tlast ? c_ST_SOP : c_ST_IN_PKT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_SOP;
            r_dest  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_push && r_state == c_ST_SOP) begin
                r_dest <= w_dest_sop;
                if (!s_tuser_hvalid) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign err_no_hdr = r_err;

    generate
        for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_out
            logic [c_EW-1:0] r_mem [FIFO_DEPTH];
            logic [c_PW-1:0] r_wr_ptr;
            logic [c_PW-1:0] r_rd_ptr;
            logic [15:0]     r_cnt;
            logic            w_wr;
            logic            w_rd;
            logic [c_EW-1:0] w_dout;

            assign w_wr          = w_push && (w_dest == c_DW'(gi));
            assign w_rd          = m_tvalid[gi] && m_tready[gi];
            assign w_fill[gi]    = r_wr_ptr - r_rd_ptr;
            assign m_tvalid[gi]  = (r_wr_ptr != r_rd_ptr);
            assign w_dout        = r_mem[r_rd_ptr[c_AW-1:0]];

            assign {m_tdata[gi*TDATA_WIDTH +: TDATA_WIDTH],
                    m_tkeep[gi*TKEEP_WIDTH +: TKEEP_WIDTH],
                    m_tlast[gi],
                    m_tuser_hvalid[gi],
                    m_tuser_hdr[gi*256 +: 256],
                    m_tuser_vendor[gi]} = w_dout;

            assign fill_level[gi*c_PW +: c_PW] = w_fill[gi];
            assign pkt_cnt[gi*16 +: 16]        = r_cnt;

            always_ff @(posedge clk) begin
                if (w_wr) begin
                    r_mem[r_wr_ptr[c_AW-1:0]] <= w_din;
                end
            end

            // Pointers carry one extra wrap bit so full and empty stay distinct.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_wr_ptr <= '0;
                    r_rd_ptr <= '0;
                    r_cnt    <= '0;
                end else begin
                    if (w_wr) begin
                        r_wr_ptr <= r_wr_ptr + c_PW'(1);
                    end
                    if (w_rd) begin
                        r_rd_ptr <= r_rd_ptr + c_PW'(1);
                    end
                    if (w_wr && s_tlast && r_cnt != 16'hFFFF) begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_ofs_fim_pcie_ss_rx_class_split.sv
`default_nettype none
// ============================================================================
// Module   : tb_ofs_fim_pcie_ss_rx_class_split
// Brief    : Self-checking bench with a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ofs_fim_pcie_ss_rx_class_split;

    localparam int c_DW    = 64;
    localparam int c_KW    = 8;
    localparam int c_NO    = 3;
    localparam int c_DEPTH = 4;
    localparam int c_PW    = 3;

    typedef struct packed {
        logic [63:0]  d;
        logic [7:0]   k;
        logic         l;
        logic         hv;
        logic [255:0] h;
        logic         v;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                    rst;
    logic                    s_tvalid, s_tready, s_tlast, s_tuser_hvalid, s_tuser_vendor;
    logic [c_DW-1:0]         s_tdata;
    logic [c_KW-1:0]         s_tkeep;
    logic [255:0]            s_tuser_hdr;
    logic [c_NO-1:0]         m_tvalid, m_tready, m_tlast, m_tuser_hvalid, m_tuser_vendor;
    logic [c_NO*c_DW-1:0]    m_tdata;
    logic [c_NO*c_KW-1:0]    m_tkeep;
    logic [c_NO*256-1:0]     m_tuser_hdr;
    logic [c_NO*c_PW-1:0]    fill_level;
    logic [c_NO*16-1:0]      pkt_cnt;
    logic                    err_no_hdr;

    // second instance exercises the two-output folding
    logic                    b_s_tvalid, b_s_tready, b_s_tlast, b_s_tuser_hvalid, b_s_tuser_vendor;
    logic [c_DW-1:0]         b_s_tdata;
    logic [c_KW-1:0]         b_s_tkeep;
    logic [255:0]            b_s_tuser_hdr;
    logic [1:0]              b_m_tvalid, b_m_tready, b_m_tlast, b_m_tuser_hvalid, b_m_tuser_vendor;
    logic [2*c_DW-1:0]       b_m_tdata;
    logic [2*c_KW-1:0]       b_m_tkeep;
    logic [2*256-1:0]        b_m_tuser_hdr;
    logic [2*c_PW-1:0]       b_fill_level;
    logic [2*16-1:0]         b_pkt_cnt;
    logic                    b_err_no_hdr;

    ofs_fim_pcie_ss_rx_class_split #(
        .TDATA_WIDTH(c_DW), .TKEEP_WIDTH(c_KW), .NUM_OUT(c_NO), .FIFO_DEPTH(c_DEPTH)
    ) u_dut (
        .clk(clk), .rst(rst),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tkeep(s_tkeep),
        .s_tlast(s_tlast), .s_tuser_hvalid(s_tuser_hvalid), .s_tuser_hdr(s_tuser_hdr),
        .s_tuser_vendor(s_tuser_vendor),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tkeep(m_tkeep),
        .m_tlast(m_tlast), .m_tuser_hvalid(m_tuser_hvalid), .m_tuser_hdr(m_tuser_hdr),
        .m_tuser_vendor(m_tuser_vendor),
        .fill_level(fill_level), .pkt_cnt(pkt_cnt), .err_no_hdr(err_no_hdr)
    );

    ofs_fim_pcie_ss_rx_class_split #(
        .TDATA_WIDTH(c_DW), .TKEEP_WIDTH(c_KW), .NUM_OUT(2), .FIFO_DEPTH(c_DEPTH)
    ) u_dut2 (
        .clk(clk), .rst(rst),
        .s_tvalid(b_s_tvalid), .s_tready(b_s_tready), .s_tdata(b_s_tdata), .s_tkeep(b_s_tkeep),
        .s_tlast(b_s_tlast), .s_tuser_hvalid(b_s_tuser_hvalid), .s_tuser_hdr(b_s_tuser_hdr),
        .s_tuser_vendor(b_s_tuser_vendor),
        .m_tvalid(b_m_tvalid), .m_tready(b_m_tready), .m_tdata(b_m_tdata), .m_tkeep(b_m_tkeep),
        .m_tlast(b_m_tlast), .m_tuser_hvalid(b_m_tuser_hvalid), .m_tuser_hdr(b_m_tuser_hdr),
        .m_tuser_vendor(b_m_tuser_vendor),
        .fill_level(b_fill_level), .pkt_cnt(b_pkt_cnt), .err_no_hdr(b_err_no_hdr)
    );

    int    tests = 0;
    int    fails = 0;
    bit    chk_en = 1'b0;
    bit    rand_done;
    beat_t mq [c_NO][$];
    logic [15:0] m_cnt [c_NO];
    bit    m_in_pkt;
    int    m_dest;
    bit    m_err;
    int    obs [c_NO];

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int route(input logic hv, input logic [7:0] ft, input int n);
        if (!hv) return n - 1;
        if (ft == 8'h0A || ft == 8'h4A) return 0;
        if (ft == 8'h00 || ft == 8'h20 || ft == 8'h40 || ft == 8'h60) return 1;
        if (ft[4:3] == 2'b10) return (n >= 3) ? 2 : 1;
        return n - 1;
    endfunction

    // Compare against the model, then advance the model across the coming edge.
    always @(negedge clk) begin : p_model
        int    cur;
        bit    exp_rdy;
        beat_t b;
        if (chk_en) begin
            if (rst) begin
                check("s_tready_in_reset", s_tready, 1'b0);
                for (int i = 0; i < c_NO; i++) begin
                    mq[i].delete();
                    m_cnt[i] = 16'd0;
                end
                m_in_pkt = 1'b0;
                m_err    = 1'b0;
            end else begin
                cur     = m_in_pkt ? m_dest : route(s_tuser_hvalid, s_tuser_hdr[31:24], c_NO);
                exp_rdy = (mq[cur].size() < c_DEPTH);
                check("s_tready", s_tready, exp_rdy);
                check("err_no_hdr", err_no_hdr, m_err);
                for (int i = 0; i < c_NO; i++) begin
                    check($sformatf("fill_level[%0d]", i), fill_level[i*c_PW +: c_PW], mq[i].size());
                    check($sformatf("m_tvalid[%0d]", i), m_tvalid[i], mq[i].size() != 0);
                    check($sformatf("pkt_cnt[%0d]", i), pkt_cnt[i*16 +: 16], m_cnt[i]);
                    if (mq[i].size() != 0) begin
                        b = {m_tdata[i*c_DW +: c_DW], m_tkeep[i*c_KW +: c_KW], m_tlast[i],
                             m_tuser_hvalid[i], m_tuser_hdr[i*256 +: 256], m_tuser_vendor[i]};
                        check($sformatf("payload[%0d]", i), b, mq[i][0]);
                    end
                    if (m_tvalid[i] && m_tready[i]) obs[i]++;
                    if (mq[i].size() != 0 && m_tready[i]) void'(mq[i].pop_front());
                end
                if (s_tvalid && exp_rdy) begin
                    mq[cur].push_back({s_tdata, s_tkeep, s_tlast, s_tuser_hvalid, s_tuser_hdr, s_tuser_vendor});
                    if (!m_in_pkt && !s_tuser_hvalid) m_err = 1'b1;
                    if (s_tlast && m_cnt[cur] != 16'hFFFF) m_cnt[cur]++;
                    m_dest   = cur;
                    m_in_pkt = !s_tlast;
                end
            end
        end
    end

    task automatic send_beat(input logic [7:0] ft, input logic hv, input logic last);
        s_tvalid       = 1'b1;
        s_tdata        = {$urandom, $urandom};
        s_tkeep        = 8'($urandom);
        s_tlast        = last;
        s_tuser_hvalid = hv;
        for (int k = 0; k < 8; k++) s_tuser_hdr[k*32 +: 32] = $urandom;
        s_tuser_hdr[31:24] = ft;
        s_tuser_vendor = 1'($urandom);
        for (int n = 0; ; n++) begin
            @(negedge clk);
            if (s_tready) break;
            if (n == 500) begin
                tests++;
                fails++;
                $display("FAIL send_timeout: s_tready stuck at %0b, required 1", s_tready);
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
    endtask

    task automatic send_pkt(input logic [7:0] ft, input logic hv, input int len, input bit gaps);
        for (int b = 0; b < len; b++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            send_beat((b == 0) ? ft : 8'($urandom), hv, b == len - 1);
        end
    endtask

    task automatic wait_drain();
        for (int n = 0; ; n++) begin
            @(negedge clk);
            if (mq[0].size() == 0 && mq[1].size() == 0 && mq[2].size() == 0) break;
            if (n == 2000) begin
                tests++;
                fails++;
                $display("FAIL drain_timeout: %0d beats still queued, required 0",
                         mq[0].size() + mq[1].size() + mq[2].size());
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst      = 1'b1;
        s_tvalid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic clear_obs();
        for (int i = 0; i < c_NO; i++) obs[i] = 0;
    endtask

    task automatic dut2_route(input string name, input logic [7:0] ft, input logic [1:0] exp_v);
        b_s_tvalid = 1'b1;
        b_s_tuser_hvalid = 1'b1;
        b_s_tlast = 1'b1;
        b_s_tuser_hdr = '0;
        b_s_tuser_hdr[31:24] = ft;
        @(negedge clk);
        check({name, "_ready"}, b_s_tready, 1'b1);
        @(posedge clk);
        #1;
        b_s_tvalid = 1'b0;
        @(negedge clk);
        check(name, b_m_tvalid, exp_v);
        b_m_tready = 2'b11;
        @(posedge clk);
        #1;
        b_m_tready = 2'b00;
        @(negedge clk);
        check({name, "_popped"}, b_m_tvalid, 2'b00);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #20000000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] ft_tab [10];
        logic [7:0] ft;
        ft_tab = '{8'h0A, 8'h4A, 8'h00, 8'h20, 8'h40, 8'h60, 8'h30, 8'h10, 8'h05, 8'h7B};
        rst = 1'b1;
        s_tvalid = 1'b0; s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0;
        s_tuser_hvalid = 1'b0; s_tuser_hdr = '0; s_tuser_vendor = 1'b0;
        m_tready = '0;
        b_s_tvalid = 1'b0; b_s_tdata = '0; b_s_tkeep = '0; b_s_tlast = 1'b0;
        b_s_tuser_hvalid = 1'b0; b_s_tuser_hdr = '0; b_s_tuser_vendor = 1'b0;
        b_m_tready = '0;
        clear_obs();
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        do_reset(3);

        // reset state and ready right after reset release
        @(negedge clk);
        check("rst_s_tready", s_tready, 1'b1);
        check("rst_fill", fill_level, '0);
        check("rst_m_tvalid", m_tvalid, '0);
        check("rst_pkt_cnt", pkt_cnt, '0);
        check("rst_err", err_no_hdr, 1'b0);
        @(posedge clk);
        #1;

        // two-output folding
        dut2_route("n2_msg30", 8'h30, 2'b10);
        dut2_route("n2_fmt05", 8'h05, 2'b10);
        dut2_route("n2_cpld", 8'h4A, 2'b01);

        // routing of CplD / MWr / Msg
        m_tready = 3'b111;
        clear_obs();
        send_pkt(8'h4A, 1'b1, 2, 1'b0);
        send_pkt(8'h60, 1'b1, 2, 1'b0);
        send_pkt(8'h30, 1'b1, 2, 1'b0);
        wait_drain();
        @(negedge clk);
        check("route_obs0", obs[0], 2);
        check("route_obs1", obs[1], 2);
        check("route_obs2", obs[2], 2);
        check("route_pkt_cnt", pkt_cnt, {16'd1, 16'd1, 16'd1});
        check("route_err_clear", err_no_hdr, 1'b0);
        @(posedge clk);
        #1;

        // missing header
        clear_obs();
        send_pkt(8'h4A, 1'b0, 1, 1'b0);
        wait_drain();
        repeat (3) @(negedge clk);
        check("nohdr_obs0", obs[0], 0);
        check("nohdr_obs2", obs[2], 1);
        check("nohdr_err", err_no_hdr, 1'b1);
        @(posedge clk);
        #1;

        // backpressure on output 0
        do_reset(2);
        @(negedge clk);
        check("bp_err_cleared", err_no_hdr, 1'b0);
        @(posedge clk);
        #1;
        clear_obs();
        m_tready = 3'b110;
        fork
            begin
                send_pkt(8'h4A, 1'b1, 6, 1'b0);
                send_pkt(8'h60, 1'b1, 2, 1'b0);
            end
            begin
                for (int n = 0; n < 100; n++) begin
                    @(negedge clk);
                    if (fill_level[0 +: c_PW] == 3'd4) break;
                end
                repeat (2) @(negedge clk);
                check("bp_s_tready", s_tready, 1'b0);
                check("bp_fill0", fill_level[0 +: c_PW], 3'd4);
                check("bp_out0_idle", obs[0], 0);
                @(posedge clk);
                #1;
                m_tready = 3'b111;
            end
        join
        wait_drain();
        @(negedge clk);
        check("bp_obs0", obs[0], 6);
        check("bp_obs1", obs[1], 2);
        @(posedge clk);
        #1;

        // reset in the middle of a 4-beat MWr
        m_tready = 3'b000;
        send_beat(8'h60, 1'b1, 1'b0);
        send_beat(8'h11, 1'b1, 1'b0);
        do_reset(1);
        @(negedge clk);
        check("midrst_fill", fill_level, '0);
        check("midrst_m_tvalid", m_tvalid, '0);
        @(posedge clk);
        #1;
        m_tready = 3'b111;
        clear_obs();
        send_pkt(8'h4A, 1'b1, 1, 1'b0);
        wait_drain();
        @(negedge clk);
        check("midrst_obs0", obs[0], 1);
        check("midrst_obs1", obs[1], 0);
        @(posedge clk);
        #1;

        // randomized traffic with random output backpressure
        rand_done = 1'b0;
        fork
            begin
                for (int p = 0; p < 300; p++) begin
                    ft = ($urandom_range(0, 4) == 0) ? 8'($urandom) : ft_tab[$urandom_range(0, 9)];
                    send_pkt(ft, $urandom_range(0, 15) != 0, $urandom_range(1, 6), 1'b1);
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    m_tready = 3'($urandom);
                end
            end
        join
        m_tready = 3'b111;
        wait_drain();

        // pkt_cnt saturation on output 1
        do_reset(1);
        for (int p = 0; p < 70000; p++) send_beat(8'h00, 1'b1, 1'b1);
        wait_drain();
        @(negedge clk);
        check("sat_cnt1", pkt_cnt[16 +: 16], 16'hFFFF);
        check("sat_cnt0", pkt_cnt[0 +: 16], 16'd0);
        @(posedge clk);
        #1;
        send_beat(8'h20, 1'b1, 1'b1);
        wait_drain();
        @(negedge clk);
        check("sat_hold", pkt_cnt[16 +: 16], 16'hFFFF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
